// File: rtl/mem_access_unit.sv
// Load/store unit: an in-order store buffer that forwards to loads, plus one
// memory port shared by store drains and load misses (one transaction at a time).
module mem_access_unit #(
  parameter int DATA_W   = 16,
  parameter int ADDR_W   = 16,
  parameter int SB_DEPTH = 4,
  parameter int RD_W     = 4
) (
  input  logic              clock,
  input  logic              rst,
  input  logic              req_valid,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  input  logic [RD_W-1:0]   req_rd,
  output logic              req_ready,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic [RD_W-1:0]   rsp_rd,
  output logic              mem_valid,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ready,
  input  logic              mem_rvalid,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              drained
);
  localparam int PTR_W = $clog2(SB_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_C = CNT_W'(SB_DEPTH);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ST_ISSUE = 2'd1,
    LD_ISSUE = 2'd2,
    LD_WAIT  = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] sb_addr_q [SB_DEPTH];
  logic [DATA_W-1:0] sb_data_q [SB_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [ADDR_W-1:0] ld_addr_q, ld_addr_d;
  logic [RD_W-1:0]   ld_rd_q, ld_rd_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
  logic [RD_W-1:0]   rsp_rd_q, rsp_rd_d;
  logic              st_acc_s, ld_acc_s, pop_s, fwd_hit_s, match_s;
  logic [DATA_W-1:0] fwd_data_s;

  // Request handshake: stores need a free slot, loads need an idle port.
  always_comb begin
    req_ready = req_valid & (req_write ? (count_q < FULL_C) : (state_q == IDLE));
    st_acc_s  = req_ready & req_write;
    ld_acc_s  = req_ready & ~req_write;
    pop_s     = (state_q == ST_ISSUE) & mem_ready;
  end

  // Forwarding search oldest-to-youngest so the youngest matching store wins.
  always_comb begin
    fwd_hit_s  = 1'b0;
    fwd_data_s = '0;
    match_s    = 1'b0;
    for (int k = 0; k < SB_DEPTH; k++) begin
      match_s    = (CNT_W'(k) < count_q) && (sb_addr_q[rd_ptr_q + PTR_W'(k)] == req_addr);
      fwd_hit_s  = fwd_hit_s | match_s;
      fwd_data_s = match_s ? sb_data_q[rd_ptr_q + PTR_W'(k)] : fwd_data_s;
    end
  end

  // Occupancy: simultaneous enqueue and pop leave the count unchanged.
  always_comb begin
    case ({st_acc_s, pop_s})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // Port sequencing; a load arriving in IDLE beats a pending drain.
  always_comb begin
    state_d     = state_q;
    ld_addr_d   = ld_addr_q;
    ld_rd_d     = ld_rd_q;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = rsp_rdata_q;
    rsp_rd_d    = rsp_rd_q;
    case (state_q)
      IDLE: begin
        if (ld_acc_s && fwd_hit_s) begin
          rsp_valid_d = 1'b1;
          rsp_rdata_d = fwd_data_s;
          rsp_rd_d    = req_rd;
        end else if (ld_acc_s) begin
          state_d   = LD_ISSUE;
          ld_addr_d = req_addr;
          ld_rd_d   = req_rd;
        end else if (count_q != '0) begin
          state_d = ST_ISSUE;
        end else begin
          state_d = IDLE;
        end
      end
      ST_ISSUE: state_d = mem_ready ? IDLE : ST_ISSUE;
      LD_ISSUE: state_d = mem_ready ? LD_WAIT : LD_ISSUE;
      LD_WAIT: begin
        if (mem_rvalid) begin
          state_d     = IDLE;
          rsp_valid_d = 1'b1;
          rsp_rdata_d = mem_rdata;
          rsp_rd_d    = ld_rd_q;
        end else begin
          state_d = LD_WAIT;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, buffer storage and response registers.
  always_ff @(posedge clock or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      ld_addr_q   <= '0;
      ld_rd_q     <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_rd_q    <= '0;
      for (int i = 0; i < SB_DEPTH; i++) begin
        sb_addr_q[i] <= '0;
        sb_data_q[i] <= '0;
      end
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      ld_addr_q   <= ld_addr_d;
      ld_rd_q     <= ld_rd_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_rd_q    <= rsp_rd_d;
      if (st_acc_s) begin
        sb_addr_q[wr_ptr_q] <= req_addr;
        sb_data_q[wr_ptr_q] <= req_wdata;
        wr_ptr_q            <= wr_ptr_q + PTR_W'(1);
      end
      if (pop_s) begin
        rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      end
    end
  end

  // Memory port is decoded from registered state; idle fields are forced to zero.
  always_comb begin
    mem_valid = (state_q == ST_ISSUE) || (state_q == LD_ISSUE);
    mem_write = (state_q == ST_ISSUE);
    case (state_q)
      ST_ISSUE: begin
        mem_addr  = sb_addr_q[rd_ptr_q];
        mem_wdata = sb_data_q[rd_ptr_q];
      end
      LD_ISSUE: begin
        mem_addr  = ld_addr_q;
        mem_wdata = '0;
      end
      default: begin
        mem_addr  = '0;
        mem_wdata = '0;
      end
    endcase
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_rd    = rsp_rd_q;
  assign drained   = (count_q == '0) && (state_q == IDLE);

endmodule
